seq_counter_param: RTL and testbench

Parametrised successor to the fixed 16-bit enabled counter user design for the eFPGA fabric. It provides an N-bit up/down counter with:
- selectable wrap or saturate arithmetic and programmable step;
- a serially loaded preload register;
- a terminal-count flag.

All control and data pass through the 28-pin user I/O bus (`io_in` / `io_out` / `io_oeb`), so the same RTL is synthesised into the fabric bitstream and instantiated as the gold model in the fabric-versus-gold bench.

---
 rtl/seq_counter_pkg.sv | 23 ++
 rtl/seq_counter_param_preload_shifter.sv | 33 +++
 rtl/seq_counter_param.sv | 89 ++++++++
 tb/tb_seq_counter_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_counter_pkg.sv
// Shared pin map, bus sizing and output-enable helper for the parametrised counter.
package seq_counter_pkg;

   localparam int unsigned IO_W      = 28;
   localparam int unsigned MAX_WIDTH = 21;

   localparam int unsigned PIN_CLR   = 0;
   localparam int unsigned PIN_EN    = 1;
   localparam int unsigned PIN_DIR   = 2;
   localparam int unsigned PIN_SDI   = 3;
   localparam int unsigned PIN_SHIFT = 4;
   localparam int unsigned PIN_LOAD  = 5;
   localparam int unsigned PIN_TC    = 6;
   localparam int unsigned PIN_COUNT = 7;

   // Active-low enables: tc plus the count field are driven, every other pad stays an input.
   function automatic logic [IO_W-1:0] oeb_mask(input int unsigned width);
      logic [IO_W-1:0] driven;
      driven = IO_W'((32'd1 << (width + 1)) - 32'd1) << PIN_TC;
      return ~driven;
   endfunction

endpackage

// File: rtl/seq_counter_param_preload_shifter.sv
// Serial-in, parallel-out preload register; MSB is shifted in first.
module preload_shifter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             shift_i,
   input  logic             sdi_i,
   output logic [WIDTH-1:0] shadow_o
);

   logic [WIDTH-1:0] shadow_q, shadow_d;

   if (WIDTH == 1) begin : g_single
      always_comb begin
         shadow_d = shadow_q;
         if (shift_i) shadow_d = sdi_i;
      end
   end else begin : g_multi
      always_comb begin
         shadow_d = shadow_q;
         if (shift_i) shadow_d = {shadow_q[WIDTH-2:0], sdi_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) shadow_q <= '0;
      else         shadow_q <= shadow_d;
   end

   assign shadow_o = shadow_q;

endmodule

// File: rtl/seq_counter_param.sv
// N-bit up/down counter with wrap/saturate arithmetic, serial preload and terminal-count flag,
// mapped onto the 28-pin user I/O bus.
module seq_counter_param
   import seq_counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned STEP     = 1,
   parameter int unsigned SATURATE = 0
) (
   input  logic            CLK,
   input  logic            resetn,
   input  logic [IO_W-1:0] io_in,
   output logic [IO_W-1:0] io_out,
   output logic [IO_W-1:0] io_oeb
);

   if (WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("seq_counter_param: WIDTH must be within 1..21");
   end
   if (STEP == 0 || STEP > (32'd1 << WIDTH) - 32'd1) begin : g_bad_step
      $error("seq_counter_param: STEP must be within 1..2^WIDTH-1");
   end

   localparam logic [WIDTH:0]   StepExt  = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH-1:0] CountMax = '1;
   localparam bit               DoSat    = (SATURATE != 0);

   logic clr, en, dir, sdi, shift, load;
   logic unused_io;

   assign clr   = io_in[PIN_CLR];
   assign en    = io_in[PIN_EN];
   assign dir   = io_in[PIN_DIR];
   assign sdi   = io_in[PIN_SDI];
   assign shift = io_in[PIN_SHIFT];
   assign load  = io_in[PIN_LOAD];
   assign unused_io = ^io_in[IO_W-1:PIN_LOAD+1];

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH:0]   sum, diff;
   logic             carry, borrow, tc;

   preload_shifter #(
      .WIDTH (WIDTH)
   ) u_preload_shifter (
      .clk_i    (CLK),
      .rst_ni   (resetn),
      .shift_i  (shift),
      .sdi_i    (sdi),
      .shadow_o (shadow)
   );

   // The extra top bit of sum/diff is the carry/borrow that decides wrap versus clamp.
   always_comb begin
      sum    = {1'b0, count_q} + StepExt;
      diff   = {1'b0, count_q} - StepExt;
      carry  = sum[WIDTH];
      borrow = diff[WIDTH];
   end

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = shadow;
      end else if (en) begin
         if (dir) count_d = (carry && DoSat) ? CountMax : sum[WIDTH-1:0];
         else     count_d = (borrow && DoSat) ? '0 : diff[WIDTH-1:0];
      end
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) count_q <= '0;
      else         count_q <= count_d;
   end

   assign tc = en & ~clr & ~load & (dir ? carry : borrow);

   always_comb begin
      io_out                     = '0;
      io_out[PIN_TC]             = tc;
      io_out[PIN_COUNT +: WIDTH] = count_q;
   end

   assign io_oeb = oeb_mask(WIDTH);

endmodule

// File: tb/tb_seq_counter_param.sv
// Scoreboard bench: a wrap/STEP=1 and a saturate/STEP=3 counter share one stimulus stream.
module tb_seq_counter_param;

   localparam int unsigned MAXV = 65535;
   localparam logic [27:0] OEB_EXP = 28'hF80003F;

   typedef struct packed {
      logic [27:0] w;
      logic [27:0] s;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic [27:0] io_in;
   logic [27:0] io_out_w, io_oeb_w, io_out_s, io_oeb_s;

   int          checks   = 0;
   int          failures = 0;
   exp_t        sb[$];

   int unsigned m_cnt[2];
   int unsigned m_shadow;

   seq_counter_param #(.WIDTH(16), .STEP(1), .SATURATE(0)) dut_w (
      .CLK    (clk),
      .resetn (resetn),
      .io_in  (io_in),
      .io_out (io_out_w),
      .io_oeb (io_oeb_w)
   );

   seq_counter_param #(.WIDTH(16), .STEP(3), .SATURATE(1)) dut_s (
      .CLK    (clk),
      .resetn (resetn),
      .io_in  (io_in),
      .io_out (io_out_s),
      .io_oeb (io_oeb_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned step_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic bit sat_of(input int i);
      return (i != 0);
   endfunction

   task automatic chk(input string name, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the counter's value range.
   function automatic logic [27:0] model_out(input int i, input bit clr, en, dir, load);
      bit tc;
      tc = en && !clr && !load &&
           (dir ? (m_cnt[i] + step_of(i) > MAXV) : (m_cnt[i] < step_of(i)));
      return (28'(m_cnt[i]) << 7) | (28'(tc) << 6);
   endfunction

   function automatic int unsigned model_next(input int i, input bit clr, en, dir, load);
      int unsigned c, st, n;
      c  = m_cnt[i];
      st = step_of(i);
      n  = c;
      if (clr) n = 0;
      else if (load) n = m_shadow;
      else if (en && dir) begin
         n = c + st;
         if (n > MAXV) n = sat_of(i) ? MAXV : n - (MAXV + 1);
      end else if (en) begin
         if (c < st) n = sat_of(i) ? 0 : c + (MAXV + 1) - st;
         else        n = c - st;
      end
      return n;
   endfunction

   // Drives one cycle at the falling edge, pushes the expected pad outputs, advances the model.
   task automatic drive(input bit clr, en, dir, sdi, shift, load);
      exp_t e;
      logic [27:0] pins;
      int unsigned n0, n1;
      @(negedge clk);
      pins      = 28'($urandom);
      pins[5:0] = {load, shift, sdi, dir, en, clr};
      io_in     = pins;
      e.w = model_out(0, clr, en, dir, load);
      e.s = model_out(1, clr, en, dir, load);
      sb.push_back(e);
      n0 = model_next(0, clr, en, dir, load);
      n1 = model_next(1, clr, en, dir, load);
      m_cnt[0] = n0;
      m_cnt[1] = n1;
      if (shift) m_shadow = ((m_shadow << 1) | 32'(sdi)) & MAXV;
      #1;
   endtask

   task automatic preload(input logic [15:0] v);
      for (int b = 15; b >= 0; b--) drive(1'b0, 1'b0, 1'b0, v[b], 1'b1, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_out_wrap", io_out_w, e.w);
            chk("sb_out_sat", io_out_s, e.s);
            chk("sb_oeb_wrap", io_oeb_w, OEB_EXP);
            chk("sb_oeb_sat", io_oeb_s, OEB_EXP);
         end
      end
   end

   initial begin : stimulus
      logic [15:0] junk;
      resetn   = 1'b0;
      io_in    = '0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_shadow = 0;
      #1;
      chk("reset_out_wrap", io_out_w, 0);
      chk("reset_out_sat", io_out_s, 0);
      chk("reset_oeb_wrap", io_oeb_w, OEB_EXP);
      chk("reset_oeb_sat", io_oeb_s, OEB_EXP);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Count up after a held clear.
      repeat (5) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (20) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("upcount_wrap", io_out_w[22:7], 20);
      chk("upcount_sat", io_out_s[22:7], 60);

      // Wrap through 0xFFFF.
      preload(16'hFFFE);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("wrap_fffe", io_out_w[22:7], 16'hFFFE);
      chk("wrap_fffe_tc", io_out_w[6], 0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("wrap_ffff", io_out_w[22:7], 16'hFFFF);
      chk("wrap_ffff_tc", io_out_w[6], 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("wrap_0000", io_out_w[22:7], 0);

      // Saturating count-down by 3.
      preload(16'h0004);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sat_4", io_out_s[22:7], 4);
      chk("sat_4_tc", io_out_s[6], 0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sat_1", io_out_s[22:7], 1);
      chk("sat_1_tc", io_out_s[6], 1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sat_0", io_out_s[22:7], 0);
      chk("sat_0_tc", io_out_s[6], 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sat_0_hold", io_out_s[22:7], 0);

      // Clear beats load beats enable.
      preload(16'h1234);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("prio_tc_masked", io_out_w[6], 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("prio_clr", io_out_w[22:7], 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("prio_load", io_out_w[22:7], 16'h1234);

      // Load takes the old shadow while the shadow shifts.
      preload(16'h8001);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("ldsh_count", io_out_w[22:7], 16'h8001);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ldsh_shadow", io_out_w[22:7], 16'h0003);

      // Asynchronous reset mid-shift.
      preload(16'h00A5);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_reset_a5", io_out_w[22:7], 16'h00A5);
      junk = 16'hBEEF;
      for (int b = 15; b > 8; b--) drive(1'b0, 1'b0, 1'b0, junk[b], 1'b1, 1'b0);
      @(posedge clk);
      #3;
      resetn   = 1'b0;
      io_in    = '0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_shadow = 0;
      #1;
      chk("async_reset_wrap", io_out_w, 0);
      chk("async_reset_sat", io_out_s, 0);
      chk("async_reset_oeb", io_oeb_w, OEB_EXP);
      @(negedge clk);
      resetn = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk("shadow_discarded", io_out_w[22:7], 0);
      preload(16'hBEEF);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reload_beef", io_out_w[22:7], 16'hBEEF);

      // Random control mix.
      for (int n = 0; n < 1500; n++) begin
         drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 75, 1'($urandom),
               1'($urandom), $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 8);
      end

      #3;
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
